// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a small first-word fall-through FIFO.
// The serial line is double-flopped, sampled at mid-bit and assembled LSB first.
// Good bytes are queued and offered through a valid/ready handshake.
// Framing errors and FIFO overruns are reported as one-cycle pulses.
// Optional feature macro: UART_RX_PARITY_EN adds an even parity bit after the
// data bits and an o_parity_err pulse output.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       o_parity_err,
`endif
  output logic       o_overrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST_CYC = CW'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK, PARITY} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

  state_t        state;
  logic          rx_meta;
  logic          rxs;
  logic [CW-1:0] cyc_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          stop_sample;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [7:0]    mem [FIFO_DEPTH];

`ifdef UART_RX_PARITY_EN
  logic          par_bit;
  logic          parity_ok;
  assign parity_ok = ~(^shift ^ par_bit);
`endif

  // Two-flop synchronizer; the line idles high so both stages reset to 1.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rxs     <= rx_meta;
    end
  end

  // The stop sample is the single cycle on which a finished byte may enter the FIFO.
  assign stop_sample = (state == STOP) && (cyc_cnt == LAST_CYC);
`ifdef UART_RX_PARITY_EN
  assign push = stop_sample && rxs && parity_ok;
`else
  assign push = stop_sample && rxs;
`endif

  assign pop     = o_valid && i_ready;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign o_valid = !empty;
  assign o_data  = mem[rd_ptr[AW-1:0]];

  // Receive FSM: find the start bit, sample each bit at its centre, check the stop bit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      cyc_cnt     <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      o_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit      <= 1'b0;
      o_parity_err <= 1'b0;
`endif
    end else begin
      o_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      o_parity_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          cyc_cnt <= '0;
          bit_cnt <= '0;
          if (!rxs) state <= START;
        end
        START: begin
          if (cyc_cnt == HALF_BIT) begin
            cyc_cnt <= '0;
            bit_cnt <= '0;
            state   <= rxs ? IDLE : DATA;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        DATA: begin
          if (cyc_cnt == LAST_CYC) begin
            cyc_cnt <= '0;
            shift   <= {rxs, shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cyc_cnt == LAST_CYC) begin
            cyc_cnt <= '0;
            par_bit <= rxs;
            state   <= STOP;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (cyc_cnt == LAST_CYC) begin
            cyc_cnt <= '0;
            if (!rxs) begin
              o_frame_err <= 1'b1;
              state       <= BREAK;
            end else begin
`ifdef UART_RX_PARITY_EN
              o_parity_err <= !parity_ok;
`endif
              state <= IDLE;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        BREAK: begin
          cyc_cnt <= '0;
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO storage and pointers; a push into a full FIFO is only accepted alongside a pop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      o_overrun <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      o_overrun <= push && full && !pop;
      if (push && (!full || pop)) begin
        mem[wr_ptr[AW-1:0]] <= shift;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule
